// File: rtl/fsm_req_gen_if.sv
// ---------------------------------------------------------------------------
// fsm_req_gen_if
// Purpose : request/grant bundle between the upstream request generator
//           (fsm_req_gen) and the 4-agent fsm_full arbiter.
// Signals : req_0..req_3  requests, driven by the generator
//           gnt_0..gnt_3  grants, driven by the arbiter
// Modports: master - request generator side (drives req, observes gnt)
//           slave  - arbiter side (observes req, drives gnt)
// ---------------------------------------------------------------------------
interface fsm_req_gen_if;
  logic req_0;
  logic req_1;
  logic req_2;
  logic req_3;
  logic gnt_0;
  logic gnt_1;
  logic gnt_2;
  logic gnt_3;

  modport master (
    output req_0, req_1, req_2, req_3,
    input  gnt_0, gnt_1, gnt_2, gnt_3
  );

  modport slave (
    input  req_0, req_1, req_2, req_3,
    output gnt_0, gnt_1, gnt_2, gnt_3
  );
endinterface

// File: rtl/fsm_req_gen.sv
// ---------------------------------------------------------------------------
// fsm_req_gen
// Purpose : upstream request generator for the 4-agent fsm_full arbiter.
//           Each agent queues job pulses in a small pending counter and runs
//           its own request FSM: request, hold the grant for HOLD_CYC
//           cycles, then drop the request for one cycle so the arbiter can
//           return to idle. Grant legality is monitored and reported.
// Params  : CNT_W     width of each pending counter (max 2^CNT_W-1 jobs)
//           HOLD_CYC  granted cycles held per job (1..255)
// Ports   : clock     rising-edge clock
//           reset     asynchronous, active-low reset (0 = reset)
//           job_0..3  one-cycle pulse, enqueue one job for agent i
//           arb       master side of fsm_req_gen_if (req_0..3 out, gnt_0..3 in)
//           pend_cnt  pending counts, agent i at [i*CNT_W +: CNT_W]
//           ovf       sticky, a job arrived while its counter was full
//           gnt_err   sticky, a protocol violation was seen on the grants
// ---------------------------------------------------------------------------
module fsm_req_gen #(
  parameter int CNT_W    = 3,
  parameter int HOLD_CYC = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 job_0,
  input  logic                 job_1,
  input  logic                 job_2,
  input  logic                 job_3,
  fsm_req_gen_if.master        arb,
  output logic [4*CNT_W-1:0]   pend_cnt,
  output logic                 ovf,
  output logic                 gnt_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_REL
  } state_t;

  localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};
  localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYC);

  logic [3:0]       job_v;
  logic [3:0]       gnt_v;

  state_t           state_q [4];
  state_t           state_d [4];
  logic [7:0]       hold_q  [4];
  logic [7:0]       hold_d  [4];
  logic [CNT_W-1:0] pend_q  [4];
  logic [CNT_W-1:0] pend_d  [4];

  logic [3:0]       req_q;
  logic [3:0]       req_d;
  logic [3:0]       done;
  logic [3:0]       agent_err;
  logic [3:0]       ovf_hit;
  logic             multi_gnt;

  assign job_v = {job_3, job_2, job_1, job_0};
  assign gnt_v = {arb.gnt_3, arb.gnt_2, arb.gnt_1, arb.gnt_0};

  assign arb.req_0 = req_q[0];
  assign arb.req_1 = req_q[1];
  assign arb.req_2 = req_q[2];
  assign arb.req_3 = req_q[3];

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_pend_out
      assign pend_cnt[g*CNT_W +: CNT_W] = pend_q[g];
    end
  endgenerate

  // More than one grant in a cycle is illegal regardless of agent state;
  // clearing the lowest set bit leaves something only if two or more are set.
  assign multi_gnt = (gnt_v & (gnt_v - 4'd1)) != 4'd0;

  // Per-agent request FSM. The IDLE decision looks at the pending count
  // before this cycle's job is added, which gives the two-edge job-to-request
  // latency. A completion is the last granted HOLD cycle. Losing the grant in
  // HOLD is an error but the agent simply falls back to REQ and tries again.
  // The request output is registered from the next state so it lines up with
  // the state register.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i]   = state_q[i];
      hold_d[i]    = hold_q[i];
      done[i]      = 1'b0;
      agent_err[i] = 1'b0;

      case (state_q[i])
        ST_IDLE: begin
          agent_err[i] = gnt_v[i];
          if (pend_q[i] != '0) begin
            state_d[i] = ST_REQ;
          end
        end
        ST_REQ: begin
          if (gnt_v[i]) begin
            state_d[i] = ST_HOLD;
            hold_d[i]  = 8'd1;
          end
        end
        ST_HOLD: begin
          if (gnt_v[i]) begin
            if (hold_q[i] == HOLD_LAST) begin
              state_d[i] = ST_REL;
              hold_d[i]  = 8'd0;
              done[i]    = 1'b1;
            end else begin
              hold_d[i] = hold_q[i] + 8'd1;
            end
          end else begin
            state_d[i]   = ST_REQ;
            hold_d[i]    = 8'd0;
            agent_err[i] = 1'b1;
          end
        end
        ST_REL: begin
          agent_err[i] = gnt_v[i];
          state_d[i]   = ST_IDLE;
        end
        default: begin
          state_d[i] = ST_IDLE;
          hold_d[i]  = 8'd0;
        end
      endcase

      req_d[i] = (state_d[i] == ST_REQ) || (state_d[i] == ST_HOLD);
    end
  end

  // Pending counters. A job and a completion in the same cycle cancel out,
  // so a full counter accepts a new job when one finishes that cycle. A job
  // hitting a full counter with no completion is dropped and flagged.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pend_d[i]  = pend_q[i];
      ovf_hit[i] = 1'b0;

      if (job_v[i] && !done[i]) begin
        if (pend_q[i] == PEND_MAX) begin
          ovf_hit[i] = 1'b1;
        end else begin
          pend_d[i] = pend_q[i] + 1'b1;
        end
      end else if (done[i] && !job_v[i] && (pend_q[i] != '0)) begin
        pend_d[i] = pend_q[i] - 1'b1;
      end
    end
  end

  // State, counters and requests. Reset drops every request at once; the
  // sticky error flags only ever accumulate until the next reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= ST_IDLE;
        hold_q[i]  <= 8'd0;
        pend_q[i]  <= '0;
      end
      req_q   <= 4'd0;
      ovf     <= 1'b0;
      gnt_err <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        hold_q[i]  <= hold_d[i];
        pend_q[i]  <= pend_d[i];
      end
      req_q   <= req_d;
      ovf     <= ovf | (|ovf_hit);
      gnt_err <= gnt_err | (|agent_err) | multi_gnt;
    end
  end

endmodule

// File: tb/tb_fsm_req_gen.sv
// ---------------------------------------------------------------------------
// tb_fsm_req_gen
// Purpose : self-checking bench for fsm_req_gen. A behavioural model tracks
//           each agent as "requesting / granted-cycle tally / release gap"
//           plus a pending job count; a small arbiter model produces grants
//           with optional fault injection. Outputs are compared on the
//           falling edge every cycle.
// ---------------------------------------------------------------------------
module tb_fsm_req_gen;

  localparam int CNT_W    = 3;
  localparam int HOLD_CYC = 4;
  localparam int PEND_MAX = (1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              job_0, job_1, job_2, job_3;
  logic [4*CNT_W-1:0] pend_cnt;
  logic              ovf;
  logic              gnt_err;

  fsm_req_gen_if arb_bus ();

  fsm_req_gen #(
    .CNT_W    (CNT_W),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .job_0    (job_0),
    .job_1    (job_1),
    .job_2    (job_2),
    .job_3    (job_3),
    .arb      (arb_bus),
    .pend_cnt (pend_cnt),
    .ovf      (ovf),
    .gnt_err  (gnt_err)
  );

  always #5 clock = ~clock;

  int total_checks = 0;
  int bad_checks   = 0;

  // Reference model: an agent is either in its release gap, not requesting,
  // or requesting with a running tally of consecutive granted cycles.
  int m_pend    [4];
  bit m_active  [4];
  bit m_gap     [4];
  int m_granted [4];
  bit m_ovf;
  bit m_err;
  int owner;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [3:0] model_req();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = m_active[i];
    return r;
  endfunction

  function automatic logic [4*CNT_W-1:0] model_pend();
    logic [4*CNT_W-1:0] p;
    for (int i = 0; i < 4; i++) p[i*CNT_W +: CNT_W] = CNT_W'(m_pend[i]);
    return p;
  endfunction

  function automatic logic [3:0] dut_req();
    return {arb_bus.req_3, arb_bus.req_2, arb_bus.req_1, arb_bus.req_0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pend[i]    = 0;
      m_active[i]  = 0;
      m_gap[i]     = 0;
      m_granted[i] = 0;
    end
    m_ovf = 0;
    m_err = 0;
    owner = -1;
  endtask

  // One rising edge of the reference: a job completes on its
  // (HOLD_CYC+1)-th consecutive granted cycle (the first grant plus the
  // HOLD_CYC-cycle tenure).
  task automatic model_step(input logic [3:0] job_v, input logic [3:0] g);
    bit complete;
    if ($countones(g) > 1) m_err = 1;
    for (int i = 0; i < 4; i++) begin
      complete = 0;
      if (m_gap[i]) begin
        if (g[i]) m_err = 1;
        m_gap[i] = 0;
      end else if (!m_active[i]) begin
        if (g[i]) m_err = 1;
        if (m_pend[i] > 0) m_active[i] = 1;
      end else if (g[i]) begin
        m_granted[i]++;
        if (m_granted[i] == HOLD_CYC + 1) begin
          complete     = 1;
          m_active[i]  = 0;
          m_gap[i]     = 1;
          m_granted[i] = 0;
        end
      end else if (m_granted[i] > 0) begin
        m_err        = 1;
        m_granted[i] = 0;
      end

      if (job_v[i] && !complete) begin
        if (m_pend[i] == PEND_MAX) m_ovf = 1;
        else m_pend[i]++;
      end else if (complete && !job_v[i] && m_pend[i] > 0) begin
        m_pend[i]--;
      end
    end
  endtask

  // Arbiter model: keeps serving its current owner while it requests,
  // otherwise picks the lowest-numbered requester. Modes: 0 clean,
  // 1 randomly withheld grants, 2 random grant garbage, 3 extra gnt_2,
  // 4 no grants at all.
  task automatic arbitrate(input int mode, output logic [3:0] g);
    logic [3:0] r;
    r = model_req();
    g = 4'd0;
    if (owner >= 0 && !r[owner]) owner = -1;
    if (owner < 0) begin
      for (int i = 0; i < 4; i++) if (r[i] && owner < 0) owner = i;
    end
    if (owner >= 0) g[owner] = 1'b1;
    case (mode)
      1: if ($urandom_range(0, 7) == 0) g = 4'd0;
      2: g = 4'($urandom_range(0, 15));
      3: g[2] = 1'b1;
      4: g = 4'd0;
      default: ;
    endcase
  endtask

  task automatic compare_all();
    checkOutput("req", 32'(dut_req()), 32'(model_req()));
    checkOutput("pend_cnt", 32'(pend_cnt), 32'(model_pend()));
    checkOutput("ovf", 32'(ovf), 32'(m_ovf));
    checkOutput("gnt_err", 32'(gnt_err), 32'(m_err));
  endtask

  // Called on a falling edge: drive one cycle of stimulus, advance the model
  // on the rising edge, then compare on the next falling edge.
  task automatic applyStimulus(input logic [3:0] job_v, input int mode);
    logic [3:0] g;
    arbitrate(mode, g);
    {job_3, job_2, job_1, job_0} = job_v;
    arb_bus.gnt_0 = g[0];
    arb_bus.gnt_1 = g[1];
    arb_bus.gnt_2 = g[2];
    arb_bus.gnt_3 = g[3];
    @(posedge clock);
    model_step(job_v, g);
    @(negedge clock);
    {job_3, job_2, job_1, job_0} = 4'd0;
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_req"}, 32'(dut_req()), 32'd0);
    checkOutput({tag, "_pend"}, 32'(pend_cnt), 32'd0);
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'd0);
    checkOutput({tag, "_err"}, 32'(gnt_err), 32'd0);
  endtask

  // Assert reset between edges, confirm outputs clear without a clock edge,
  // keep inputs toggling while held, then release on a falling edge.
  task automatic reset_phase(input int cycles);
    reset = 1'b0;
    #1;
    check_reset_values("rst_async");
    model_reset();
    for (int c = 0; c < cycles; c++) begin
      {job_3, job_2, job_1, job_0} = 4'($urandom_range(0, 15));
      {arb_bus.gnt_3, arb_bus.gnt_2, arb_bus.gnt_1, arb_bus.gnt_0} = 4'($urandom_range(0, 15));
      @(negedge clock);
      check_reset_values("rst_hold");
    end
    {job_3, job_2, job_1, job_0} = 4'd0;
    {arb_bus.gnt_3, arb_bus.gnt_2, arb_bus.gnt_1, arb_bus.gnt_0} = 4'd0;
    reset = 1'b1;
  endtask

  task automatic random_run(input int cycles, input bit faulty);
    logic [3:0] jv;
    int mode;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 4; i++) jv[i] = ($urandom_range(0, 9) == 0);
      mode = faulty ? int'($urandom_range(0, 2)) : 0;
      applyStimulus(jv, mode);
    end
  endtask

  initial begin
    reset = 1'b0;
    {job_3, job_2, job_1, job_0} = 4'd0;
    {arb_bus.gnt_3, arb_bus.gnt_2, arb_bus.gnt_1, arb_bus.gnt_0} = 4'd0;
    model_reset();

    @(negedge clock);
    reset_phase(4);

    // No job, no request.
    for (int c = 0; c < 5; c++) applyStimulus(4'd0, 0);
    checkOutput("idle_no_req", 32'(dut_req()), 32'd0);

    // Single job on agent 0: request two edges after the pulse.
    applyStimulus(4'b0001, 0);
    checkOutput("job0_k1_req0", 32'(arb_bus.req_0), 32'd0);
    applyStimulus(4'b0000, 0);
    checkOutput("job0_k2_req0", 32'(arb_bus.req_0), 32'd1);
    for (int c = 0; c < 12; c++) applyStimulus(4'd0, 0);
    checkOutput("job0_pend_done", 32'(pend_cnt[0 +: CNT_W]), 32'd0);

    // Three back-to-back jobs on agent 2.
    applyStimulus(4'b0100, 0);
    applyStimulus(4'b0100, 0);
    applyStimulus(4'b0100, 0);
    checkOutput("job2_burst_pend", 32'(pend_cnt[2*CNT_W +: CNT_W]), 32'd3);
    for (int c = 0; c < 30; c++) applyStimulus(4'd0, 0);

    // Simultaneous jobs on agents 0 and 3.
    applyStimulus(4'b1001, 0);
    applyStimulus(4'b0000, 0);
    checkOutput("contend_both_req", 32'({arb_bus.req_3, arb_bus.req_0}), 32'd3);
    for (int c = 0; c < 25; c++) applyStimulus(4'd0, 0);
    checkOutput("contend_no_err", 32'(gnt_err), 32'd0);

    // Overflow on agent 1 with the arbiter stalled.
    for (int c = 0; c < 8; c++) applyStimulus(4'b0010, 4);
    checkOutput("ovf_pend1", 32'(pend_cnt[CNT_W +: CNT_W]), 32'd7);
    checkOutput("ovf_flag", 32'(ovf), 32'd1);
    // Jobs every cycle while served: completions cancel arrivals.
    for (int c = 0; c < 20; c++) applyStimulus(4'b0010, 0);
    for (int c = 0; c < 60; c++) applyStimulus(4'd0, 0);

    // Clean randomized traffic from a fresh reset.
    reset_phase(2);
    random_run(1500, 0);
    checkOutput("random_clean_err", 32'(gnt_err), 32'd0);

    // Protocol errors.
    reset_phase(2);
    applyStimulus(4'd0, 3);
    checkOutput("unsolicited_gnt2", 32'(gnt_err), 32'd1);
    applyStimulus(4'b0001, 0);
    applyStimulus(4'd0, 0);
    applyStimulus(4'd0, 0);
    applyStimulus(4'd0, 0);
    applyStimulus(4'd0, 4);
    checkOutput("lost_gnt_req0", 32'(arb_bus.req_0), 32'd1);
    applyStimulus(4'd0, 0);
    applyStimulus(4'd0, 0);
    applyStimulus(4'd0, 0);
    reset_phase(2);

    // Randomized traffic with grant faults.
    random_run(800, 1);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
